// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution window scheduler.
// Holds the FSM state encoding, default geometry and width helpers.
package conv_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRun     = 2'd1,
        StWaitOut = 2'd2,
        StDone    = 2'd3
    } state_e;

    localparam int unsigned DEF_IMG_W = 8;
    localparam int unsigned DEF_IMG_H = 8;
    localparam int unsigned DEF_K     = 3;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

    // Counters and ports with a single legal value still need one bit.
    function automatic int unsigned width_of(input int unsigned v);
        return (clog2(v) > 0) ? clog2(v) : 1;
    endfunction

endpackage

// File: rtl/loop_counter.sv
// Modulo-MAX counter with synchronous clear; wraps to zero on en while at MAX-1.
// Chained by the scheduler to walk the kernel taps and output positions.
module loop_counter #(
    parameter int unsigned W   = 4,
    parameter int unsigned MAX = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] value,
    output logic         last
);

    logic [W-1:0] r_value;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_value <= '0;
        end else if (clr) begin
            r_value <= '0;
        end else if (en) begin
            r_value <= last ? '0 : r_value + W'(1);
        end
    end

    assign value = r_value;
    assign last  = (r_value == W'(MAX - 1));

endmodule

// File: rtl/conv_window_scheduler.sv
// Walks every (orow, ocol, kr, kc) position of a stride-1, unpadded convolution,
// driving memory addresses, MAC strobes and a valid/ready hand-off of each output.
module conv_window_scheduler
    import conv_pkg::*;
#(
    parameter  int unsigned IMG_W   = DEF_IMG_W,
    parameter  int unsigned IMG_H   = DEF_IMG_H,
    parameter  int unsigned K       = DEF_K,
    parameter  int unsigned ADDR_W  = 6,
    localparam int unsigned OW      = IMG_W - K + 1,
    localparam int unsigned OH      = IMG_H - K + 1,
    localparam int unsigned KADDR_W = width_of(K * K),
    localparam int unsigned OADDR_W = width_of(OW * OH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               mem_ready,
    input  logic               out_ready,
    output logic [ADDR_W-1:0]  img_addr,
    output logic [KADDR_W-1:0] ker_addr,
    output logic               mac_en,
    output logic               acc_clr,
    output logic               out_valid,
    output logic [OADDR_W-1:0] out_addr,
    output logic               busy,
    output logic               done
);

    localparam int unsigned KC_W = width_of(K);
    localparam int unsigned OC_W = width_of(OW);
    localparam int unsigned OR_W = width_of(OH);

    state_e r_state;
    state_e w_state_next;

    logic [KC_W-1:0] w_kc;
    logic [KC_W-1:0] w_kr;
    logic [OC_W-1:0] w_ocol;
    logic [OR_W-1:0] w_orow;
    logic            w_kc_last;
    logic            w_kr_last;
    logic            w_ocol_last;
    logic            w_orow_last;

    logic w_clr;
    logic w_kr_en;
    logic w_ocol_en;
    logic w_orow_en;
    logic w_last_tap;
    logic w_last_out;

    // Each outer counter only moves when the one nested inside it wraps.
    assign w_clr      = (r_state == StIdle) & start;
    assign w_kr_en    = mac_en & w_kc_last;
    assign w_ocol_en  = (r_state == StWaitOut) & out_ready;
    assign w_orow_en  = w_ocol_en & w_ocol_last;
    assign w_last_tap = mac_en & w_kr_last & w_kc_last;
    assign w_last_out = w_ocol_last & w_orow_last;

    loop_counter #(.W(KC_W), .MAX(K)) u_kc (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_clr),
        .en    (mac_en),
        .value (w_kc),
        .last  (w_kc_last)
    );

    loop_counter #(.W(KC_W), .MAX(K)) u_kr (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_clr),
        .en    (w_kr_en),
        .value (w_kr),
        .last  (w_kr_last)
    );

    loop_counter #(.W(OC_W), .MAX(OW)) u_ocol (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_clr),
        .en    (w_ocol_en),
        .value (w_ocol),
        .last  (w_ocol_last)
    );

    loop_counter #(.W(OR_W), .MAX(OH)) u_orow (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_clr),
        .en    (w_orow_en),
        .value (w_orow),
        .last  (w_orow_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:    if (start) w_state_next = StRun;
            StRun:     if (w_last_tap) w_state_next = StWaitOut;
            StWaitOut: if (out_ready) w_state_next = w_last_out ? StDone : StRun;
            StDone:    w_state_next = StIdle;
            default:   w_state_next = StIdle;
        endcase
    end

    always_comb begin
        mac_en    = (r_state == StRun) & mem_ready;
        acc_clr   = mac_en & (w_kr == '0) & (w_kc == '0);
        out_valid = (r_state == StWaitOut);
        done      = (r_state == StDone);
        busy      = (r_state != StIdle);
    end

    // 32-bit intermediates keep the products exact before truncation to port width.
    assign img_addr = ADDR_W'((32'(w_orow) + 32'(w_kr)) * IMG_W + 32'(w_ocol) + 32'(w_kc));
    assign ker_addr = KADDR_W'(32'(w_kr) * K + 32'(w_kc));
    assign out_addr = OADDR_W'(32'(w_orow) * OW + 32'(w_ocol));

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Directed bench for conv_window_scheduler: full passes with stalls, back-pressure,
// mid-pass reset and restart, plus K=1 and single-output geometries.
module tb_conv_window_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, mem_ready, out_ready;
    logic [5:0] img_addr;
    logic [3:0] ker_addr;
    logic       mac_en, acc_clr, out_valid, busy, done;
    logic [5:0] out_addr;

    logic       a_start, a_mac, a_clr, a_valid, a_busy, a_done;
    logic [3:0] a_img, a_oaddr;
    logic [0:0] a_ker;

    logic       b_start, b_mac, b_clr, b_valid, b_busy, b_done;
    logic [3:0] b_img, b_ker;
    logic [0:0] b_oaddr;

    conv_window_scheduler u_dut (
        .clk (clk), .rst (rst), .start (start), .mem_ready (mem_ready), .out_ready (out_ready),
        .img_addr (img_addr), .ker_addr (ker_addr), .mac_en (mac_en), .acc_clr (acc_clr),
        .out_valid (out_valid), .out_addr (out_addr), .busy (busy), .done (done)
    );

    conv_window_scheduler #(.IMG_W(4), .IMG_H(4), .K(1), .ADDR_W(4)) u_k1 (
        .clk (clk), .rst (rst), .start (a_start), .mem_ready (mem_ready), .out_ready (out_ready),
        .img_addr (a_img), .ker_addr (a_ker), .mac_en (a_mac), .acc_clr (a_clr),
        .out_valid (a_valid), .out_addr (a_oaddr), .busy (a_busy), .done (a_done)
    );

    conv_window_scheduler #(.IMG_W(3), .IMG_H(3), .K(3), .ADDR_W(4)) u_k3 (
        .clk (clk), .rst (rst), .start (b_start), .mem_ready (mem_ready), .out_ready (out_ready),
        .img_addr (b_img), .ker_addr (b_ker), .mac_en (b_mac), .acc_clr (b_clr),
        .out_valid (b_valid), .out_addr (b_oaddr), .busy (b_busy), .done (b_done)
    );

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    int q1[$];
    int q3[$];
    int n_mac, n_hs, n_done, cyc_n;
    int a_hs, a_dn, a_mc, b_hs, b_dn, b_tap;
    int win0[9] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic fill_q();
        exp_q.delete();
        for (int i = 0; i < 36; i++) exp_q.push_back(i);
        n_mac  = 0;
        n_hs   = 0;
        n_done = 0;
    endtask

    // Record this cycle's strobes and score any handshake, then advance one clock.
    task automatic cycle();
        if (mac_en) n_mac++;
        if (done) n_done++;
        if (out_valid && out_ready) begin
            n_hs++;
            if (exp_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
            else check("sb_out_addr", 32'(out_addr), 32'(exp_q.pop_front()));
        end
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic run_to_done();
        while (!done && cyc_n < 600) cycle();
        if (done) cycle();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_img"}, 32'(img_addr), 32'd0);
        check({tag, "_ker"}, 32'(ker_addr), 32'd0);
        check({tag, "_mac"}, 32'(mac_en), 32'd0);
        check({tag, "_clr"}, 32'(acc_clr), 32'd0);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_oaddr"}, 32'(out_addr), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; mem_ready = 1'b0; out_ready = 1'b0;
        a_start = 1'b0; b_start = 1'b0;
        cyc_n = 0;
        #12;
        start = 1'b1; mem_ready = 1'b1; out_ready = 1'b1;
        #1;
        check_all_zero("reset");
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Full pass, no stalls.
        fill_q();
        start = 1'b1; #1;
        cyc_n = 0;
        cycle();
        start = 1'b0; #1;
        while (!done && cyc_n < 600) begin
            if (cyc_n >= 1 && cyc_n <= 9) begin
                check("w0_img", 32'(img_addr), 32'(win0[cyc_n-1]));
                check("w0_ker", 32'(ker_addr), 32'(cyc_n - 1));
                check("w0_clr", 32'(acc_clr), 32'(cyc_n == 1));
            end
            if (cyc_n == 351) begin
                check("w35_img", 32'(img_addr), 32'd45);
                check("w35_clr", 32'(acc_clr), 32'd1);
            end
            cycle();
        end
        check("t1_done_cycle", 32'(cyc_n), 32'd361);
        check("t1_busy_at_done", 32'(busy), 32'd1);
        if (done) cycle();
        check("t1_busy_after", 32'(busy), 32'd0);
        check("t1_ndone", 32'(n_done), 32'd1);
        check("t1_nhs", 32'(n_hs), 32'd36);
        check("t1_nmac", 32'(n_mac), 32'd324);
        check("t1_q_left", 32'(exp_q.size()), 32'd0);

        // Memory stall of 3 cycles at tap 4.
        fill_q();
        start = 1'b1; #1;
        cyc_n = 0;
        cycle();
        start = 1'b0; #1;
        repeat (4) cycle();
        mem_ready = 1'b0; #1;
        repeat (3) begin
            check("stall_img", 32'(img_addr), 32'd9);
            check("stall_ker", 32'(ker_addr), 32'd4);
            check("stall_mac", 32'(mac_en), 32'd0);
            cycle();
        end
        mem_ready = 1'b1; #1;
        check("resume_ker", 32'(ker_addr), 32'd4);
        check("resume_mac", 32'(mac_en), 32'd1);
        while (!done && cyc_n < 600) cycle();
        check("t2_done_cycle", 32'(cyc_n), 32'd364);
        if (done) cycle();
        check("t2_nmac", 32'(n_mac), 32'd324);
        check("t2_nhs", 32'(n_hs), 32'd36);
        check("t2_ndone", 32'(n_done), 32'd1);

        // Writer back-pressure for 5 cycles on the first output.
        fill_q();
        out_ready = 1'b0;
        start = 1'b1; #1;
        cyc_n = 0;
        cycle();
        start = 1'b0; #1;
        repeat (9) cycle();
        repeat (5) begin
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_oaddr", 32'(out_addr), 32'd0);
            check("bp_img", 32'(img_addr), 32'd0);
            check("bp_mac", 32'(mac_en), 32'd0);
            cycle();
        end
        out_ready = 1'b1; #1;
        cycle();
        check("bp_next_img", 32'(img_addr), 32'd1);
        check("bp_next_clr", 32'(acc_clr), 32'd1);
        check("bp_next_valid", 32'(out_valid), 32'd0);
        // start held high from mid-pass through DONE.
        start = 1'b1; #1;
        run_to_done();
        check("t3_nhs", 32'(n_hs), 32'd36);
        check("t3_ndone", 32'(n_done), 32'd1);
        check("held_idle_busy", 32'(busy), 32'd0);
        fill_q();
        cyc_n = 0;
        cycle();
        start = 1'b0; #1;
        check("held_restart_busy", 32'(busy), 32'd1);
        check("held_restart_img", 32'(img_addr), 32'd0);
        check("held_restart_clr", 32'(acc_clr), 32'd1);

        // Run to (orow=2, ocol=3, kr=1) with a stray start, then reset.
        while (cyc_n < 154 && !done) begin
            start = (cyc_n == 60); #1;
            cycle();
        end
        start = 1'b0; #1;
        check("mid_img", 32'(img_addr), 32'd27);
        check("mid_ker", 32'(ker_addr), 32'd3);
        check("mid_oaddr", 32'(out_addr), 32'd15);
        check("mid_nhs", 32'(n_hs), 32'd15);
        check("mid_ndone", 32'(n_done), 32'd0);
        #2;
        rst = 1'b0; #1;
        check_all_zero("midrst");
        @(posedge clk); #1;
        check("midrst_nodone", 32'(done), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        fill_q();
        start = 1'b1; #1;
        cyc_n = 0;
        cycle();
        start = 1'b0; #1;
        check("rs_img", 32'(img_addr), 32'd0);
        check("rs_ker", 32'(ker_addr), 32'd0);
        check("rs_clr", 32'(acc_clr), 32'd1);
        check("rs_oaddr", 32'(out_addr), 32'd0);
        while (!done && cyc_n < 600) cycle();
        check("rs_done_cycle", 32'(cyc_n), 32'd361);
        if (done) cycle();
        check("rs_nhs", 32'(n_hs), 32'd36);

        // K=1 on 4x4, and K equal to image size (single output).
        q1.delete();
        for (int i = 0; i < 16; i++) q1.push_back(i);
        q3.delete();
        q3.push_back(0);
        a_hs = 0; a_dn = 0; a_mc = 0; b_hs = 0; b_dn = 0; b_tap = 0;
        a_start = 1'b1; b_start = 1'b1; #1;
        @(posedge clk); #1;
        a_start = 1'b0; b_start = 1'b0; #1;
        for (int c = 0; c < 60; c++) begin
            check("k1_clr", 32'(a_clr), 32'(a_mac));
            if (a_mac) begin
                a_mc++;
                if (q1.size() > 0) check("k1_img", 32'(a_img), 32'(q1[0]));
            end
            if (a_valid) begin
                a_hs++;
                if (q1.size() == 0) check("k1_underflow", 32'd1, 32'd0);
                else check("k1_oaddr", 32'(a_oaddr), 32'(q1.pop_front()));
            end
            if (a_done) a_dn++;
            if (b_mac) begin
                check("k3_img", 32'(b_img), 32'(b_tap));
                check("k3_ker", 32'(b_ker), 32'(b_tap));
                b_tap++;
            end
            if (b_valid) begin
                b_hs++;
                if (q3.size() == 0) check("k3_underflow", 32'd1, 32'd0);
                else check("k3_oaddr", 32'(b_oaddr), 32'(q3.pop_front()));
            end
            if (b_done) b_dn++;
            @(posedge clk); #1;
        end
        check("k1_nhs", 32'(a_hs), 32'd16);
        check("k1_nmac", 32'(a_mc), 32'd16);
        check("k1_ndone", 32'(a_dn), 32'd1);
        check("k3_nhs", 32'(b_hs), 32'd1);
        check("k3_ntap", 32'(b_tap), 32'd9);
        check("k3_ndone", 32'(b_dn), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
